// File: rtl/sm_eth_reset_seq.sv
// ============================================================================
// sm_eth_reset_seq : Ethernet subsystem reset sequencer with staggered release
// Rev 1.0
// ============================================================================
`default_nettype none

module sm_eth_reset_seq #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ninit_done,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] resetn,
  output logic                   rst_done,
  output logic [1:0]             state
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] ninit_sync_q, ninit_sync_d;
  logic [SYNC_STAGES-1:0] pll_sync_q, pll_sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] resetn_q, resetn_d;
  logic                   rst_done_q, rst_done_d;
  logic                   init_ok;

  assign init_ok = ~ninit_sync_q[SYNC_STAGES-1] & pll_sync_q[SYNC_STAGES-1];

  always_comb begin
    ninit_sync_d = {ninit_sync_q[SYNC_STAGES-2:0], ninit_done};
    pll_sync_d   = {pll_sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    resetn_d     = resetn_q;
    rst_done_d   = rst_done_q;

    if (state_q == WAIT_INIT) begin
      resetn_d   = '0;
      rst_done_d = 1'b0;
      if (init_ok) begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end else if (!init_ok) begin
      // Loss of init/lock outranks a software request
      state_d    = WAIT_INIT;
      cnt_d      = '0;
      idx_d      = '0;
      resetn_d   = '0;
      rst_done_d = 1'b0;
    end else if (sw_reset_req) begin
      state_d    = HOLD;
      cnt_d      = '0;
      idx_d      = '0;
      resetn_d   = '0;
      rst_done_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == C_HOLD_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == C_STAG_LAST) begin
            resetn_d[idx_q] = 1'b1;
            cnt_d           = '0;
            if (idx_q == C_IDX_LAST) begin
              state_d    = DONE;
              rst_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          resetn_d   = '1;
          rst_done_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ninit_sync_q <= '1;
      pll_sync_q   <= '0;
      state_q      <= WAIT_INIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      resetn_q     <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      ninit_sync_q <= ninit_sync_d;
      pll_sync_q   <= pll_sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      resetn_q     <= resetn_d;
      rst_done_q   <= rst_done_d;
    end
  end

  assign resetn   = resetn_q;
  assign rst_done = rst_done_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_eth_reset_seq.sv
// ============================================================================
// tb_sm_eth_reset_seq : directed bench with elapsed-time reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sm_eth_reset_seq;

  localparam int N  = 4;
  localparam int H  = 16;
  localparam int ST = 8;
  localparam int S  = 2;

  logic         clk = 1'b0;
  logic         rst, ninit, pll, sw;
  logic [N-1:0] resetn;
  logic         rst_done;
  logic [1:0]   state;

  int n_pass  = 0;
  int n_total = 0;

  sm_eth_reset_seq #(
    .NUM_DOMAINS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(ST), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(rst), .ninit_done(ninit), .pll_locked(pll),
    .sw_reset_req(sw), .resetn(resetn), .rst_done(rst_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: the sequence is a pure function of edges elapsed since HOLD entry
  logic [S-1:0] m_nin, m_pll;
  bit           m_active = 0;
  bit           m_valid  = 0;
  int           m_e      = 0;
  bit           m_ok;

  always @(posedge clk) begin
    m_ok = ~m_nin[S-1] & m_pll[S-1];
    if (rst) begin
      m_active = 0; m_e = 0; m_nin = '1; m_pll = '0; m_valid = 1;
    end else begin
      if (!m_active) begin
        if (m_ok) begin m_active = 1; m_e = 0; end
      end else if (!m_ok) begin
        m_active = 0; m_e = 0;
      end else if (sw) begin
        m_e = 0;
      end else if (m_e < 100000) begin
        m_e++;
      end
      m_nin = {m_nin[S-2:0], ninit};
      m_pll = {m_pll[S-2:0], pll};
    end
  end

  always @(negedge clk) begin
    int k, exp_st, exp_rn, exp_done;
    if (m_valid) begin
      if (!m_active) begin
        exp_st = 0; exp_rn = 0; exp_done = 0;
      end else begin
        k = (m_e < H) ? 0 : (m_e - H) / ST;
        if (k > N) k = N;
        exp_st   = (m_e < H) ? 1 : ((k == N) ? 3 : 2);
        exp_rn   = (1 << k) - 1;
        exp_done = (k == N) ? 1 : 0;
      end
      chk("model_state", 32'(state), 32'(exp_st));
      chk("model_resetn", 32'(resetn), 32'(exp_rn));
      chk("model_rst_done", 32'(rst_done), 32'(exp_done));
    end
  end

  task automatic wait_e(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for 5 edges; inputs go ready before the last reset edge (E0)
  task automatic power_up();
    rst = 1; ninit = 1; pll = 0; sw = 0;
    wait_e(4);
    pll = 1; ninit = 0;
    wait_e(1);
    rst = 0;
  endtask

  initial begin
    rst = 1; ninit = 1; pll = 0; sw = 0;

    // Power-up with default parameters
    power_up();
    wait_e(1); chk("reset_state", 32'(state), 32'd0);
    chk("reset_resetn", 32'(resetn), 32'd0);
    wait_e(1); chk("pu_e2_wait", 32'(state), 32'd0);
    wait_e(1); chk("pu_e3_hold", 32'(state), 32'd1);
    wait_e(23); chk("pu_e26_none", 32'(resetn), 32'h0);
    wait_e(1); chk("pu_e27_r1", 32'(resetn), 32'h1);
    wait_e(8); chk("pu_e35_r2", 32'(resetn), 32'h3);
    wait_e(8); chk("pu_e43_r3", 32'(resetn), 32'h7);
    chk("pu_e43_notdone", 32'(rst_done), 32'd0);
    wait_e(8); chk("pu_e51_r4", 32'(resetn), 32'hF);
    chk("pu_e51_done", 32'(rst_done), 32'd1);
    chk("pu_e51_state", 32'(state), 32'd3);

    // Software re-sequence from DONE
    sw = 1; wait_e(1); sw = 0;
    chk("sw_hold", 32'(state), 32'd1);
    chk("sw_resetn", 32'(resetn), 32'h0);
    chk("sw_done", 32'(rst_done), 32'd0);
    wait_e(15); chk("sw_still_hold", 32'(state), 32'd1);
    wait_e(1); chk("sw_release", 32'(state), 32'd2);
    wait_e(8); chk("sw_r1", 32'(resetn), 32'h1);
    wait_e(8); chk("sw_r2", 32'(resetn), 32'h3);
    wait_e(8); chk("sw_r3", 32'(resetn), 32'h7);
    wait_e(8); chk("sw_r4", 32'(resetn), 32'hF);
    chk("sw_r4_done", 32'(rst_done), 32'd1);

    // Request during HOLD at cnt=10 restarts the hold count
    sw = 1; wait_e(1); sw = 0;
    wait_e(10);
    sw = 1; wait_e(1); sw = 0;
    chk("hr_hold", 32'(state), 32'd1);
    wait_e(15); chk("hr_still_hold", 32'(state), 32'd1);
    wait_e(1); chk("hr_release", 32'(state), 32'd2);

    // Request coinciding with loss of init_ok: abort wins
    pll = 0; wait_e(2);
    sw = 1; wait_e(1); sw = 0;
    chk("abort_vs_sw_state", 32'(state), 32'd0);
    chk("abort_vs_sw_resetn", 32'(resetn), 32'h0);
    pll = 1;

    // PLL loss mid-release, then relock
    power_up();
    wait_e(35); chk("pl_e35", 32'(resetn), 32'h3);
    pll = 0;
    wait_e(2); chk("pl_e37_still", 32'(resetn), 32'h3);
    wait_e(1); chk("pl_e38_state", 32'(state), 32'd0);
    chk("pl_e38_resetn", 32'(resetn), 32'h0);
    chk("pl_e38_done", 32'(rst_done), 32'd0);
    pll = 1;
    wait_e(2); chk("pl_relock_wait", 32'(state), 32'd0);
    wait_e(1); chk("pl_relock_hold", 32'(state), 32'd1);
    wait_e(24); chk("pl_relock_r1", 32'(resetn), 32'h1);
    wait_e(24); chk("pl_relock_r4", 32'(resetn), 32'hF);
    chk("pl_relock_done", 32'(rst_done), 32'd1);

    // Init never done
    rst = 1; ninit = 1; pll = 1;
    wait_e(3);
    rst = 0;
    for (int i = 0; i < 200; i++) begin
      wait_e(1);
      chk("never_init", {27'd0, state, resetn, rst_done}, 32'd0);
    end

    // Reset mid-RELEASE also returns the synchronizers to not-ready
    power_up();
    wait_e(43); chk("rr_e43", 32'(resetn), 32'h7);
    rst = 1; wait_e(1); rst = 0;
    chk("rr_state", 32'(state), 32'd0);
    chk("rr_resetn", 32'(resetn), 32'h0);
    wait_e(2); chk("rr_sync_cleared", 32'(state), 32'd0);
    wait_e(1); chk("rr_hold", 32'(state), 32'd1);

    wait_e(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_eth_reset_seq.md
Name: sm_eth_reset_seq

Overview:
Reset sequencer for the Ethernet subsystem. It waits for FPGA init-done and PLL lock, holds every domain reset asserted for a fixed time, then releases NUM_DOMAINS active-low domain resets one by one at fixed intervals, in index order. It drives the resetn signal of each per-domain reset interface (AXI, MAC, PHY, DMA) and supports software-requested re-sequencing.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset domains (1..16)
HOLD_CYCLES, 16, cycles all resets stay asserted after init_ok (>=1)
STAGGER_CYCLES, 8, cycles between successive domain releases (>=1)
SYNC_STAGES, 2, synchronizer depth for ninit_done and pll_locked (>=2)

Ports:
clk  input  1  single clock for all logic
reset  input  1  synchronous, active-high block reset
ninit_done  input  1  async, active-low FPGA init-done
pll_locked  input  1  async, active-high PLL lock
sw_reset_req  input  1  sync single-cycle pulse requesting re-sequence
resetn  output  NUM_DOMAINS  active-low domain resets; bit i released i-th
rst_done  output  1  high when all domains are released
state  output  2  FSM state (debug)

Behaviour:
- Synchronizers: SYNC_STAGES flops per async input. On reset, the ninit_done chain loads 1 and the pll_locked chain loads 0. init_ok = ~ninit_done_s & pll_locked_s, combinational from the last stage.
- reset=1 at an edge forces the following: state=WAIT_INIT, resetn=0, rst_done=0, counters=0. Every output is a register.
- States (encoding): WAIT_INIT=0, HOLD=1, RELEASE=2, DONE=3.
- WAIT_INIT: all resetn=0. When init_ok=1, go to HOLD and set cnt=0.
- HOLD: cnt increments each cycle. At cnt==HOLD_CYCLES-1, go to RELEASE and set cnt=0, idx=0. HOLD lasts exactly HOLD_CYCLES cycles.
- RELEASE: cnt increments. At cnt==STAGGER_CYCLES-1, resetn[idx] is set to 1, cnt is set to 0 and idx increments.
  - When idx==NUM_DOMAINS-1, go to DONE instead, and set rst_done=1 on the same edge that releases the last domain.
  - resetn[i] rises STAGGER_CYCLES*(i+1) cycles after RELEASE entry.
  - Released bits stay high. resetn is always thermometer-coded from bit 0.
- DONE: resetn all 1, rst_done=1. The block holds here until an abort or a request.
- Abort (init_ok==0 in HOLD, RELEASE or DONE): on the next edge, resetn=0, rst_done=0, state=WAIT_INIT, counters cleared.
- sw_reset_req=1 in HOLD, RELEASE or DONE, with init_ok=1: on the next edge, resetn=0, rst_done=0, state=HOLD, cnt=0. A request during HOLD restarts the hold count.
- sw_reset_req in WAIT_INIT is ignored.
- Priority when events coincide: reset > abort > sw_reset_req > normal progression.
- Counter width is $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1). The counter never wraps, because it always clears at its terminal value.
- Glitch-free: no resetn bit rises except through RELEASE. Every deassertion is synchronous to clk.
- NUM_DOMAINS=1: the single release edge goes directly to DONE.

Test Plan:
- Power-up, defaults: reset for 5 cycles, then pll_locked=1 and ninit_done falls before edge E0. Required: state=HOLD after E3; resetn=4'b0001 after E27, 4'b0011 after E35, 4'b0111 after E43, 4'b1111 and rst_done=1 after E51.
- Init never done: ninit_done held 1 and pll_locked=1 for 200 cycles. Required: state=0, resetn=0, rst_done=0 throughout.
- PLL loss mid-release: drop pll_locked while resetn=4'b0011. Required: SYNC_STAGES+1 cycles later, resetn=0, rst_done=0, state=0. After relock, the full sequence repeats with the same timing as the power-up test.
- sw_reset_req in DONE: one-cycle pulse. Required: next edge resetn=0, rst_done=0, state=1; 16 cycles later state=2; the four releases follow at +8, +16, +24 and +32 cycles.
- Request during HOLD at cnt=10: required that HOLD restarts, giving a total HOLD time of 11+16 cycles. A request and pll_locked loss in the same cycle: required that the abort wins and state=0.
- Reset mid-RELEASE: assert reset at resetn=4'b0111. Required: next edge resetn=0, state=0, and the synchronizer outputs are back to the not-ready value.
